// File: rtl/layer_cfg_queue_pkg.sv
// Shared parameters, sizing helpers and record field layout for layer_cfg_queue.
// Error flags are built only when LAYER_CFG_ERRCHK_EN is defined.
package layer_cfg_queue_pkg;

   localparam int unsigned PORT_W_DEF = 32;
   localparam int unsigned CFG_W_DEF  = 96;
   localparam int unsigned DEPTH_DEF  = 16;
   localparam int unsigned LAY_W_DEF  = 8;

   // Beats per record, first beat lands in the most significant bits
   function automatic int unsigned nb_of(input int unsigned cfg_w, input int unsigned port_w);
      return (cfg_w + port_w - 1) / port_w;
   endfunction

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned bc_w(input int unsigned nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

   localparam int unsigned NB_DEF    = nb_of(CFG_W_DEF, PORT_W_DEF);
   localparam int unsigned PTR_W_DEF = ptr_w(DEPTH_DEF);

   // Field offsets within a default-width record, split downstream
   localparam int unsigned CFG_FIELD_W = 32;
   localparam int unsigned CFG_HDR_LSB = 64;
   localparam int unsigned CFG_WGT_LSB = 32;
   localparam int unsigned CFG_ACT_LSB = 0;

   typedef struct packed {
      logic [CFG_FIELD_W-1:0] hdr;
      logic [CFG_FIELD_W-1:0] wgt;
      logic [CFG_FIELD_W-1:0] act;
   } cfg_rec_t;

endpackage

// File: rtl/cfg_ram.sv
// Record storage for layer_cfg_queue: 1W1R, registered read address, no reset on contents.
module cfg_ram
   import layer_cfg_queue_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned CFG_W = CFG_W_DEF,
   parameter int unsigned PTR_W = PTR_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [CFG_W-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [CFG_W-1:0] rdata
);

   logic [CFG_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] raddr_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) raddr_q <= '0;
      else        raddr_q <= raddr;
   end

   assign rdata = mem[raddr_q];

endmodule

// File: rtl/layer_cfg_queue.sv
// Assembles config beats into records, queues them and presents one record per layer.
// Optional sticky {overflow, underflow} flags under LAYER_CFG_ERRCHK_EN.
module layer_cfg_queue
   import layer_cfg_queue_pkg::*;
#(
   parameter int unsigned PORT_W = PORT_W_DEF,
   parameter int unsigned CFG_W  = CFG_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned LAY_W  = LAY_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  Flush,
   input  logic                  IFCFG_Val,
   input  logic [PORT_W-1:0]     IFCFG,
   output logic                  IFCFG_Rdy,
   input  logic                  Rst_Layer,
   output logic [CFG_W-1:0]      CFG_Word,
   output logic                  CFG_Vld,
   output logic [LAY_W-1:0]      CFG_LayIdx,
   output logic [ptr_w(DEPTH):0] Cnt,
   output logic                  Empty,
   output logic                  Full,
   output logic [1:0]            Err
);

   localparam int unsigned NB    = nb_of(CFG_W, PORT_W);
   localparam int unsigned ACC_W = NB * PORT_W;
   localparam int unsigned PTR_W = ptr_w(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned BC_W  = bc_w(NB);

   logic [BC_W-1:0]  beat_cnt, beat_cnt_nxt;
   logic [ACC_W-1:0] acc, acc_nxt, acc_shift;
   logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CFG_W-1:0] word_nxt, rd_data, wr_data;
   logic [LAY_W-1:0] lay_nxt;
   logic             vld_nxt;
   logic             beat_ok, push, pop, under, ram_we;

   assign Full      = (cnt == CNT_W'(DEPTH));
   assign Empty     = (cnt == '0);
   assign IFCFG_Rdy = !Full;
   assign Cnt       = cnt;

   assign beat_ok   = IFCFG_Val && !Full;
   assign push      = beat_ok && (beat_cnt == BC_W'(NB - 1));
   assign pop       = Rst_Layer && !Empty;
   assign under     = Rst_Layer && Empty;
   assign ram_we    = push && !Flush;

   // Record including the beat on the bus this cycle; zero-padded low, top CFG_W bits kept
   assign acc_shift = (acc << PORT_W) | ACC_W'(IFCFG);
   assign wr_data   = acc_shift[ACC_W-1 -: CFG_W];

   // Read address is the post-edge read pointer, so rd_data always shows the head
   cfg_ram #(
      .DEPTH (DEPTH),
      .CFG_W (CFG_W),
      .PTR_W (PTR_W)
   ) u_cfg_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (ram_we),
      .waddr (wr_ptr),
      .wdata (wr_data),
      .raddr (rd_ptr_nxt),
      .rdata (rd_data)
   );

   always_comb begin
      beat_cnt_nxt = beat_cnt;
      acc_nxt      = acc;
      wr_ptr_nxt   = wr_ptr;
      rd_ptr_nxt   = rd_ptr;
      cnt_nxt      = cnt;
      word_nxt     = CFG_Word;
      vld_nxt      = CFG_Vld;
      lay_nxt      = CFG_LayIdx;
      if (Flush) begin
         beat_cnt_nxt = '0;
         wr_ptr_nxt   = '0;
         rd_ptr_nxt   = '0;
         cnt_nxt      = '0;
         vld_nxt      = 1'b0;
         lay_nxt      = '0;
      end else begin
         if (beat_ok) begin
            acc_nxt      = acc_shift;
            beat_cnt_nxt = push ? '0 : beat_cnt + BC_W'(1);
         end
         if (push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
            word_nxt   = rd_data;
            vld_nxt    = 1'b1;
            if (CFG_Vld) lay_nxt = CFG_LayIdx + LAY_W'(1);
         end else if (under) begin
            vld_nxt = 1'b0;
         end
         if (push && !pop)      cnt_nxt = cnt + CNT_W'(1);
         else if (!push && pop) cnt_nxt = cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt   <= '0;
         acc        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         CFG_Word   <= '0;
         CFG_Vld    <= 1'b0;
         CFG_LayIdx <= '0;
      end else begin
         beat_cnt   <= beat_cnt_nxt;
         acc        <= acc_nxt;
         wr_ptr     <= wr_ptr_nxt;
         rd_ptr     <= rd_ptr_nxt;
         cnt        <= cnt_nxt;
         CFG_Word   <= word_nxt;
         CFG_Vld    <= vld_nxt;
         CFG_LayIdx <= lay_nxt;
      end
   end

`ifdef LAYER_CFG_ERRCHK_EN
   logic [1:0] err_q, err_nxt;

   // Sticky {overflow, underflow}; Flush clears
   always_comb begin
      err_nxt = err_q;
      if (Flush) begin
         err_nxt = 2'b00;
      end else begin
         if (IFCFG_Val && Full) err_nxt[1] = 1'b1;
         if (under)             err_nxt[0] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 2'b00;
      else        err_q <= err_nxt;
   end

   assign Err = err_q;
`else
   assign Err = 2'b00;
`endif

endmodule

// File: tb/tb_layer_cfg_queue.sv
// Self-checking bench for layer_cfg_queue (default parameters): queue model plus literal checks.
module tb_layer_cfg_queue;

`ifdef LAYER_CFG_ERRCHK_EN
   localparam bit ERRCHK = 1'b1;
`else
   localparam bit ERRCHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        Flush = 1'b0;
   logic        IFCFG_Val = 1'b0;
   logic [31:0] IFCFG = '0;
   logic        IFCFG_Rdy;
   logic        Rst_Layer = 1'b0;
   logic [95:0] CFG_Word;
   logic        CFG_Vld;
   logic [7:0]  CFG_LayIdx;
   logic [4:0]  Cnt;
   logic        Empty, Full;
   logic [1:0]  Err;

   int total = 0;
   int bad = 0;

   layer_cfg_queue dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Flush      (Flush),
      .IFCFG_Val  (IFCFG_Val),
      .IFCFG      (IFCFG),
      .IFCFG_Rdy  (IFCFG_Rdy),
      .Rst_Layer  (Rst_Layer),
      .CFG_Word   (CFG_Word),
      .CFG_Vld    (CFG_Vld),
      .CFG_LayIdx (CFG_LayIdx),
      .Cnt        (Cnt),
      .Empty      (Empty),
      .Full       (Full),
      .Err        (Err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [95:0] rec(input int i);
      return {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i)};
   endfunction

   // Model: a plain queue of whole records plus the layer-presentation registers
   logic [95:0] mq[$];
   int          m_beats = 0;
   logic [95:0] m_part = '0;
   logic [95:0] m_word = '0;
   logic        m_vld = 1'b0;
   logic [7:0]  m_lay = '0;
   logic [1:0]  m_err = '0;
   bit          m_full;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mq.delete();
         m_beats = 0; m_part = '0; m_word = '0; m_vld = 1'b0; m_lay = '0; m_err = '0;
      end else if (Flush) begin
         mq.delete();
         m_beats = 0; m_vld = 1'b0; m_lay = '0; m_err = '0;
      end else begin
         m_full = (mq.size() == 16);
         if (IFCFG_Val && m_full) m_err[1] = 1'b1;
         if (Rst_Layer && mq.size() == 0) begin
            m_vld = 1'b0;
            m_err[0] = 1'b1;
         end else if (Rst_Layer) begin
            m_word = mq.pop_front();
            if (m_vld) m_lay = m_lay + 8'd1;
            m_vld = 1'b1;
         end
         if (IFCFG_Val && !m_full) begin
            m_part = {m_part[63:0], IFCFG};
            m_beats++;
            if (m_beats == 3) begin
               mq.push_back(m_part);
               m_beats = 0;
            end
         end
      end
   end

   // Every-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("m_cnt",   96'(Cnt),        96'(mq.size()));
         chk("m_empty", 96'(Empty),      96'(mq.size() == 0));
         chk("m_full",  96'(Full),       96'(mq.size() == 16));
         chk("m_rdy",   96'(IFCFG_Rdy),  96'(mq.size() != 16));
         chk("m_vld",   96'(CFG_Vld),    96'(m_vld));
         chk("m_lay",   96'(CFG_LayIdx), 96'(m_lay));
         chk("m_word",  CFG_Word,        m_word);
         chk("m_err",   96'(Err),        ERRCHK ? 96'(m_err) : 96'(0));
      end
   end

   task automatic cyc(input bit v, input logic [31:0] d, input bit rl, input bit fl);
      IFCFG_Val = v; IFCFG = d; Rst_Layer = rl; Flush = fl;
      @(negedge clk);
   endtask

   task automatic send_rec(input logic [95:0] r);
      for (int b = 0; b < 3; b++) cyc(1'b1, r[95 - 32*b -: 32], 1'b0, 1'b0);
   endtask

   initial begin
      logic [95:0] r;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      // Reset state
      chk("rst_cnt",   96'(Cnt), 96'(0));
      chk("rst_empty", 96'(Empty), 96'(1));
      chk("rst_full",  96'(Full), 96'(0));
      chk("rst_rdy",   96'(IFCFG_Rdy), 96'(1));
      chk("rst_vld",   96'(CFG_Vld), 96'(0));
      chk("rst_word",  CFG_Word, 96'(0));
      chk("rst_lay",   96'(CFG_LayIdx), 96'(0));
      chk("rst_err",   96'(Err), 96'(0));

      // Basic three-beat record then pop
      cyc(1'b1, 32'hAAAA0001, 1'b0, 1'b0);
      cyc(1'b1, 32'hBBBB0002, 1'b0, 1'b0);
      cyc(1'b1, 32'hCCCC0003, 1'b0, 1'b0);
      chk("basic_cnt1", 96'(Cnt), 96'(1));
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("basic_word", CFG_Word, 96'hAAAA0001_BBBB0002_CCCC0003);
      chk("basic_vld",  96'(CFG_Vld), 96'(1));
      chk("basic_lay",  96'(CFG_LayIdx), 96'(0));
      chk("basic_cnt0", 96'(Cnt), 96'(0));

      // Underflow on empty queue
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("und_vld",  96'(CFG_Vld), 96'(0));
      chk("und_word", CFG_Word, 96'hAAAA0001_BBBB0002_CCCC0003);
      chk("und_err0", 96'(Err[0]), 96'(ERRCHK));
      chk("und_lay",  96'(CFG_LayIdx), 96'(0));

      // Fill to 16, offer one more beat, drain in order
      cyc(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) send_rec(rec(i));
      cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
      chk("ovf_full", 96'(Full), 96'(1));
      chk("ovf_rdy",  96'(IFCFG_Rdy), 96'(0));
      chk("ovf_err1", 96'(Err[1]), 96'(ERRCHK));
      chk("ovf_cnt",  96'(Cnt), 96'(16));
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         chk($sformatf("drain_word%0d", i), CFG_Word, rec(i));
         chk($sformatf("drain_lay%0d", i), 96'(CFG_LayIdx), 96'(i));
      end
      chk("drain_empty", 96'(Empty), 96'(1));
      chk("drain_err",   96'(Err), ERRCHK ? 96'(2) : 96'(0));

      // Last beat coinciding with a pop keeps Cnt
      cyc(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) send_rec(rec(100 + i));
      r = rec(103);
      cyc(1'b1, r[95:64], 1'b0, 1'b0);
      cyc(1'b1, r[63:32], 1'b0, 1'b0);
      cyc(1'b1, r[31:0],  1'b1, 1'b0);
      chk("same_cnt",  96'(Cnt), 96'(3));
      chk("same_word", CFG_Word, rec(100));
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("same_last", CFG_Word, rec(103));

      // Reset mid-record discards the partial record
      r = rec(150);
      cyc(1'b1, r[95:64], 1'b0, 1'b0);
      cyc(1'b1, r[63:32], 1'b0, 1'b0);
      IFCFG_Val = 1'b0;
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_cnt",  96'(Cnt), 96'(0));
      chk("mid_rst_word", CFG_Word, 96'(0));
      send_rec(rec(200));
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("fresh_word", CFG_Word, rec(200));
      chk("fresh_lay",  96'(CFG_LayIdx), 96'(0));

      // Flush with five queued records
      for (int i = 0; i < 5; i++) send_rec(rec(300 + i));
      chk("pre_flush_cnt", 96'(Cnt), 96'(5));
      cyc(1'b0, '0, 1'b0, 1'b1);
      chk("flush_cnt",   96'(Cnt), 96'(0));
      chk("flush_empty", 96'(Empty), 96'(1));
      chk("flush_vld",   96'(CFG_Vld), 96'(0));
      chk("flush_word",  CFG_Word, rec(200));

      cyc(1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/layer_cfg_queue.md
LAYER_CFG_QUEUE -- requirements
Module: layer_cfg_queue

Interface
REQ-001 SHALL have parameters: PORT_W default 32 (config port width); CFG_W default 96 (record width); DEPTH default 16 (records, power of 2); LAY_W default 8 (layer index width).
REQ-002 SHALL have ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous clear.
- IFCFG_Val  in  1  beat valid.
- IFCFG  in  PORT_W  config beat.
- IFCFG_Rdy  out  1  beat accepted when Val&&Rdy.
- Rst_Layer  in  1  one-cycle pulse that advances to the next layer.
- CFG_Word  out  CFG_W  current-layer record; fields are split downstream.
- CFG_Vld  out  1  CFG_Word holds a valid record.
- CFG_LayIdx  out  LAY_W  index of current layer.
- Cnt  out  log2(DEPTH)+1  queued records.
- Empty  out  1  no queued records.
- Full  out  1  queue full.
- Err  out  2  {overflow, underflow} sticky.

Function
REQ-003 SHALL assemble each record from NB=ceil(CFG_W/PORT_W) beats, first beat most significant; last beat zero-padded low and truncated to CFG_W.
REQ-004 SHALL use a beat counter 0..NB-1 as the assembly state (COLLECT); on acceptance of beat NB-1 the record SHALL be written to the queue at that same edge and the counter SHALL return to 0.
REQ-005 IFCFG_Rdy SHALL equal !Full (combinational); beats SHALL NOT be accepted while Full, including the last beat of a record.
REQ-006 SHALL pop the head at an edge where Rst_Layer=1 and Cnt>0: the head record SHALL be registered into CFG_Word, and CFG_Vld SHALL be 1 from the following cycle (1-cycle latency).
REQ-007 When Vld was already 1 before the pop, CFG_LayIdx SHALL increment by 1 on that pop, wrapping modulo 2^LAY_W; the first pop after reset/Flush SHALL leave CFG_LayIdx at 0.
REQ-008 Rst_Layer with Cnt==0 SHALL clear CFG_Vld, hold CFG_Word and CFG_LayIdx, and set underflow.
REQ-009 A record completing in the same cycle as a pop SHALL make Cnt unchanged; a pop with Cnt==0 SHALL NOT bypass a record completing in that same cycle.
REQ-010 Read/write pointers SHALL wrap modulo DEPTH; Full=(Cnt==DEPTH); Empty=(Cnt==0).
REQ-011 IFCFG_Val=1 while Full SHALL set overflow; the beat SHALL be dropped by the source-held handshake (no data loss inside the block).
REQ-012 Flush SHALL at the next edge clear pointers, Cnt, beat counter, CFG_Vld, CFG_LayIdx and Err, and SHALL override a simultaneous push or pop; CFG_Word SHALL be held.

Reset
REQ-013 rst_n low SHALL asynchronously clear CFG_Word, CFG_Vld, CFG_LayIdx, Cnt, pointers, beat counter and Err to 0; Empty SHALL be 1 and Full 0; queue storage SHALL NOT be reset.
REQ-014 Reset asserted mid-record SHALL discard the partial record.

Configuration
REQ-015 Macro LAYER_CFG_ERRCHK_EN defined: Err SHALL be implemented per REQ-008/011.
REQ-016 Macro LAYER_CFG_ERRCHK_EN undefined: Err SHALL be constant 0 and no flag flops SHALL exist.

Structure
REQ-017 NB, the pointer width and the default values of PORT_W, CFG_W and DEPTH SHALL live in the shared dw_params package/include; CFG field offsets SHALL be defined there as well.
REQ-018 Storage SHALL be one sub-module cfg_ram (1W1R, DEPTH x CFG_W, registered read address); assembly, pointers and handshake SHALL be in the top.

Verification
REQ-019 PORT_W=32, CFG_W=96: beats 0xAAAA0001, 0xBBBB0002, 0xCCCC0003, then Rst_Layer -> next cycle CFG_Word=0xAAAA0001_BBBB0002_CCCC0003, CFG_Vld=1, CFG_LayIdx=0, Cnt=0.
REQ-020 Push 16 records, then offer a 17th beat -> Full=1, IFCFG_Rdy=0, Err[1]=1, Cnt=16; 16 pops return records in order with LayIdx 0..15.
REQ-021 Rst_Layer on empty after one consumed record -> CFG_Vld=0, CFG_Word held, Err[0]=1, LayIdx unchanged.
REQ-022 Cnt=3, last beat of a record coinciding with Rst_Layer -> Cnt stays 3, correct head popped.
REQ-023 Assert rst_n low after 2 of 3 beats, then send 3 fresh beats -> record equals only the fresh beats; Flush with Cnt=5 -> Cnt=0, Empty=1, CFG_Vld=0.
REQ-024 Run REQ-020 without LAYER_CFG_ERRCHK_EN -> Err stays 2'b00.
